// File: rtl/lc2k_regfile_wb.sv
// -----------------------------------------------------------------------------
// lc2k_regfile_wb
//
// LC2K architectural register file (2^ADDR_WIDTH x DATA_WIDTH) with a
// one-entry write-back latch. The latch sits right after the write-data mux.
// A write is captured into the latch on one edge and committed to the array
// on the next edge. Commit and capture share an edge, so back-to-back
// writes stream with no bubble.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : read ports A/B forward the latch data when a pending write
//               targets the same (nonzero) index. A write is then readable
//               1 cycle after its edge.
//   undefined : read ports A/B return array contents only. A write is
//               readable 2 cycles after its edge. The hazard unit must
//               stall on wb_pending && wb_reg match.
//   dbg_data is never bypassed in either build.
//
// Ports
//   clk          in   single clock, all state updates on the rising edge
//   reset        in   synchronous, active-high; clears array, latch, counter
//   wr_en        in   write request this cycle
//   wr_reg       in   destination register (writes to r0 are discarded)
//   write_value  in   data from the write-data mux
//   rd_reg_a/b   in   read port indices
//   rd_data_a/b  out  read port data, combinational
//   dbg_reg      in   debug read index
//   dbg_data     out  array contents at dbg_reg, combinational, no bypass
//   wb_pending   out  latch holds an uncommitted write
//   wb_reg       out  destination held in the latch (valid when wb_pending)
//   commit_count out  number of committed writes, saturating at all-ones
// -----------------------------------------------------------------------------
module lc2k_regfile_wb #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 3,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [ADDR_WIDTH-1:0]  wr_reg,
    input  logic [DATA_WIDTH-1:0]  write_value,
    input  logic [ADDR_WIDTH-1:0]  rd_reg_a,
    input  logic [ADDR_WIDTH-1:0]  rd_reg_b,
    output logic [DATA_WIDTH-1:0]  rd_data_a,
    output logic [DATA_WIDTH-1:0]  rd_data_b,
    input  logic [ADDR_WIDTH-1:0]  dbg_reg,
    output logic [DATA_WIDTH-1:0]  dbg_data,
    output logic                   wb_pending,
    output logic [ADDR_WIDTH-1:0]  wb_reg,
    output logic [COUNT_WIDTH-1:0] commit_count
);

    localparam int NumRegs = 1 << ADDR_WIDTH;

`ifdef REGFILE_BYPASS_EN
    localparam bit BypassEn = 1'b1;
`else
    localparam bit BypassEn = 1'b0;
`endif

    // Architectural state
    logic [DATA_WIDTH-1:0]  regs [NumRegs];
    logic                   pend;
    logic [ADDR_WIDTH-1:0]  lreg;
    logic [DATA_WIDTH-1:0]  ldata;
    logic [COUNT_WIDTH-1:0] commitCount;

    // A write to r0 is dropped at capture time. It never reaches the latch,
    // so it never produces a commit or a count.
    logic captureNow;
    assign captureNow = wr_en && (wr_reg != '0);

    // Saturating increment for the commit counter.
    function automatic logic [COUNT_WIDTH-1:0] satIncrement(
        input logic [COUNT_WIDTH-1:0] cnt
    );
        if (&cnt) begin
            return cnt;
        end
        return cnt + COUNT_WIDTH'(1);
    endfunction

    // Read-port resolution: r0 is hard zero. Otherwise a matching pending
    // latch entry wins (bypass build only), and the array supplies the rest.
    function automatic logic [DATA_WIDTH-1:0] resolveRead(
        input logic [ADDR_WIDTH-1:0] idx,
        input logic [DATA_WIDTH-1:0] arrayVal,
        input logic                  hitPend,
        input logic [ADDR_WIDTH-1:0] hitReg,
        input logic [DATA_WIDTH-1:0] hitData
    );
        if (idx == '0) begin
            return '0;
        end
        if (BypassEn && hitPend && (hitReg == idx)) begin
            return hitData;
        end
        return arrayVal;
    endfunction

    // Commit the previous capture and capture the new write on the same edge.
    // Commit uses the latch contents from before this edge. A same-register
    // write therefore lands one cycle after the previous one, and the later
    // value wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs[i] <= '0;
            end
            pend        <= 1'b0;
            lreg        <= '0;
            ldata       <= '0;
            commitCount <= '0;
        end else begin
            if (pend) begin
                regs[lreg]  <= ldata;
                commitCount <= satIncrement(commitCount);
            end
            pend <= captureNow;
            if (captureNow) begin
                lreg  <= wr_reg;
                ldata <= write_value;
            end
        end
    end

    always_comb begin
        rd_data_a = resolveRead(rd_reg_a, regs[rd_reg_a], pend, lreg, ldata);
        rd_data_b = resolveRead(rd_reg_b, regs[rd_reg_b], pend, lreg, ldata);
        // Debug dump shows committed architectural state only.
        dbg_data  = (dbg_reg == '0) ? '0 : regs[dbg_reg];
    end

    assign wb_pending   = pend;
    assign wb_reg       = lreg;
    assign commit_count = commitCount;

endmodule

// File: tb/tb_lc2k_regfile_wb.sv
// -----------------------------------------------------------------------------
// tb_lc2k_regfile_wb
//
// Directed testbench for lc2k_regfile_wb, built with COUNT_WIDTH=4 so that
// counter saturation is reachable. The stimulus process drives one cycle at
// a time. For each cycle it queues the hand-computed output values expected
// while those inputs are held. The monitor samples on the falling edge and
// pops every entry queued for the current cycle.
// -----------------------------------------------------------------------------
module tb_lc2k_regfile_wb;

`ifdef REGFILE_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    localparam int SelA = 0, SelB = 1, SelDbg = 2, SelPend = 3, SelWbReg = 4, SelCnt = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        wrEn;
    logic [2:0]  wrReg;
    logic [31:0] writeValue;
    logic [2:0]  rdRegA, rdRegB, dbgReg;
    logic [31:0] rdDataA, rdDataB, dbgData;
    logic        wbPending;
    logic [2:0]  wbReg;
    logic [3:0]  commitCount;

    lc2k_regfile_wb #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (3),
        .COUNT_WIDTH(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wrEn),
        .wr_reg      (wrReg),
        .write_value (writeValue),
        .rd_reg_a    (rdRegA),
        .rd_reg_b    (rdRegB),
        .rd_data_a   (rdDataA),
        .rd_data_b   (rdDataB),
        .dbg_reg     (dbgReg),
        .dbg_data    (dbgData),
        .wb_pending  (wbPending),
        .wb_reg      (wbReg),
        .commit_count(commitCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          sel;
        string       name;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   cyc     = 0;
    int   applied = 0;
    int   miscmp  = 0;

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            SelA:     return rdDataA;
            SelB:     return rdDataB;
            SelDbg:   return dbgData;
            SelPend:  return {31'd0, wbPending};
            SelWbReg: return {29'd0, wbReg};
            default:  return {28'd0, commitCount};
        endcase
    endfunction

    // Monitor: compares every entry scheduled for the current cycle.
    always @(negedge clk) begin
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            chk_t e;
            logic [31:0] act;
            e = q.pop_front();
            applied++;
            act = pick(e.sel);
            if (e.cyc < cyc) begin
                miscmp++;
                $display("FAIL %s: check for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
            end else if (act !== e.exp) begin
                miscmp++;
                $display("FAIL %s @cyc %0d: got 0x%08h, expected 0x%08h", e.name, cyc, act, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic we, input logic [2:0] wr, input logic [31:0] v,
                         input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] dg);
        wrEn       = we;
        wrReg      = wr;
        writeValue = v;
        rdRegA     = ra;
        rdRegB     = rb;
        dbgReg     = dg;
    endtask

    task automatic expectVal(input int sel, input string nm, input logic [31:0] v);
        chk_t e;
        e.cyc  = cyc;
        e.sel  = sel;
        e.name = nm;
        e.exp  = v;
        q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 3'd0, 32'd0, 3'd0, 3'd0, 3'd0);
        tick();

        // ---- reset state ----
        reset = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 3'd3, 3'd1, 3'd3);
        expectVal(SelPend, "rst_pend", 32'd0);
        expectVal(SelCnt,  "rst_cnt",  32'd0);
        expectVal(SelA,    "rst_rdA",  32'd0);
        expectVal(SelDbg,  "rst_dbg",  32'd0);
        tick();

        // ---- preload r3, r1 then reset with a write request ----
        drive(1'b1, 3'd3, 32'h0000_00A3, 3'd3, 3'd1, 3'd3);
        tick();
        drive(1'b1, 3'd1, 32'h0000_00B1, 3'd3, 3'd1, 3'd3);
        expectVal(SelPend,  "pre_pend",  32'd1);
        expectVal(SelWbReg, "pre_wbreg", 32'd3);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd3, 3'd1, 3'd3);
        expectVal(SelDbg, "pre_dbg3", 32'h0000_00A3);
        expectVal(SelCnt, "pre_cnt1", 32'd1);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd3, 3'd1, 3'd1);
        expectVal(SelDbg,  "pre_dbg1",  32'h0000_00B1);
        expectVal(SelCnt,  "pre_cnt2",  32'd2);
        expectVal(SelPend, "pre_pend0", 32'd0);
        reset = 1'b1;
        drive(1'b1, 3'd3, 32'h5555_5555, 3'd3, 3'd1, 3'd1);
        tick();
        reset = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 3'd3, 3'd1, 3'd3);
        expectVal(SelDbg,  "rst2_dbg3", 32'd0);
        expectVal(SelCnt,  "rst2_cnt",  32'd0);
        expectVal(SelPend, "rst2_pend", 32'd0);
        expectVal(SelA,    "rst2_rdA3", 32'd0);
        expectVal(SelB,    "rst2_rdB1", 32'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd3, 3'd1, 3'd3);
        expectVal(SelDbg, "rst2_r3_unwritten", 32'd0);
        expectVal(SelA,   "rst2_rdA3_later",   32'd0);
        expectVal(SelCnt, "rst2_cnt_later",    32'd0);

        // ---- single write r5 = DEADBEEF ----
        drive(1'b1, 3'd5, 32'hDEAD_BEEF, 3'd5, 3'd0, 3'd5);
        expectVal(SelA, "sw_before", 32'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd5, 3'd0, 3'd5);
        expectVal(SelPend,  "sw_pend",  32'd1);
        expectVal(SelWbReg, "sw_wbreg", 32'd5);
        expectVal(SelA,     "sw_rdA_e", Byp ? 32'hDEAD_BEEF : 32'd0);
        expectVal(SelDbg,   "sw_dbg_e", 32'd0);
        expectVal(SelCnt,   "sw_cnt_e", 32'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd5, 3'd0, 3'd5);
        expectVal(SelDbg,  "sw_dbg_e1",  32'hDEAD_BEEF);
        expectVal(SelA,    "sw_rdA_e1",  32'hDEAD_BEEF);
        expectVal(SelCnt,  "sw_cnt_e1",  32'd1);
        expectVal(SelPend, "sw_pend_e1", 32'd0);
        tick();

        // ---- back-to-back r2 <- 1, r2 <- 2 ----
        drive(1'b1, 3'd2, 32'd1, 3'd2, 3'd0, 3'd2);
        tick();
        drive(1'b1, 3'd2, 32'd2, 3'd2, 3'd0, 3'd2);
        expectVal(SelA,     "b2b_rdA_1", Byp ? 32'd1 : 32'd0);
        expectVal(SelPend,  "b2b_pend",  32'd1);
        expectVal(SelWbReg, "b2b_wbreg", 32'd2);
        expectVal(SelCnt,   "b2b_cnt_1", 32'd1);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd2, 3'd0, 3'd2);
        expectVal(SelA,   "b2b_rdA_2", Byp ? 32'd2 : 32'd1);
        expectVal(SelDbg, "b2b_dbg_2", 32'd1);
        expectVal(SelCnt, "b2b_cnt_2", 32'd2);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd2, 3'd0, 3'd2);
        expectVal(SelA,   "b2b_rdA_3", 32'd2);
        expectVal(SelDbg, "b2b_dbg_3", 32'd2);
        expectVal(SelCnt, "b2b_cnt_3", 32'd3);
        tick();

        // ---- r0 discard ----
        drive(1'b1, 3'd0, 32'h0000_1234, 3'd0, 3'd0, 3'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd0, 3'd0, 3'd0);
        expectVal(SelPend, "r0_pend", 32'd0);
        expectVal(SelB,    "r0_rdB",  32'd0);
        expectVal(SelA,    "r0_rdA",  32'd0);
        expectVal(SelCnt,  "r0_cnt",  32'd3);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd0, 3'd0, 3'd0);
        expectVal(SelCnt, "r0_cnt_later", 32'd3);
        expectVal(SelDbg, "r0_dbg",       32'd0);

        // ---- dual read r1 = 7, r6 = FFFFFFFF ----
        drive(1'b1, 3'd1, 32'd7, 3'd1, 3'd6, 3'd0);
        tick();
        drive(1'b1, 3'd6, 32'hFFFF_FFFF, 3'd1, 3'd6, 3'd0);
        expectVal(SelA, "dual_rdA_0", Byp ? 32'd7 : 32'd0);
        expectVal(SelB, "dual_rdB_0", 32'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd1, 3'd6, 3'd6);
        expectVal(SelA,   "dual_rdA_1", 32'd7);
        expectVal(SelB,   "dual_rdB_1", Byp ? 32'hFFFF_FFFF : 32'd0);
        expectVal(SelDbg, "dual_dbg6",  32'd0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd1, 3'd6, 3'd6);
        expectVal(SelA,   "dual_rdA", 32'd7);
        expectVal(SelB,   "dual_rdB", 32'hFFFF_FFFF);
        expectVal(SelDbg, "dual_dbg", 32'hFFFF_FFFF);
        expectVal(SelCnt, "dual_cnt", 32'd5);

        // ---- saturation: reset, then 17 writes to r4 ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            int c;
            drive(1'b1, 3'd4, 32'h100 + 32'(i), 3'd0, 3'd0, 3'd4);
            // Writes 0..i-2 have committed by the time write i is presented.
            c = (i >= 2) ? i - 1 : 0;
            if (c > 15) c = 15;
            expectVal(SelCnt, $sformatf("sat_cnt_%0d", i), 32'(c));
            tick();
        end
        drive(1'b0, 3'd0, 32'd0, 3'd4, 3'd0, 3'd4);
        expectVal(SelCnt, "sat_cnt_16c", 32'hF);
        tick();
        drive(1'b0, 3'd0, 32'd0, 3'd4, 3'd0, 3'd4);
        expectVal(SelCnt,  "sat_cnt_hold", 32'hF);
        expectVal(SelDbg,  "sat_r4_last",  32'h110);
        expectVal(SelA,    "sat_rdA_last", 32'h110);
        expectVal(SelPend, "sat_pend",     32'd0);
        tick();
        tick();

        applied++;
        if (q.size() != 0) begin
            miscmp++;
            $display("FAIL drain: %0d checks left unconsumed, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscmp);
        $finish;
    end

endmodule
